// File: rtl/easyaxi_rd_mst_if.sv
// AXI read-address and read-data channel bundle used between the read master and a slave.
// The master drives AR payload and rready; the slave drives arready and the R beat.
interface easyaxi_rd_mst_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              axi_mst_arvalid;
  logic              axi_mst_arready;
  logic [ID_W-1:0]   axi_mst_arid;
  logic [ADDR_W-1:0] axi_mst_araddr;
  logic [7:0]        axi_mst_arlen;
  logic [2:0]        axi_mst_arsize;
  logic [1:0]        axi_mst_arburst;
  logic              axi_mst_rvalid;
  logic              axi_mst_rready;
  logic [ID_W-1:0]   axi_mst_rid;
  logic [DATA_W-1:0] axi_mst_rdata;
  logic [1:0]        axi_mst_rresp;
  logic              axi_mst_rlast;

  modport master (
    output axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
           axi_mst_arsize, axi_mst_arburst, axi_mst_rready,
    input  axi_mst_arready, axi_mst_rvalid, axi_mst_rid, axi_mst_rdata,
           axi_mst_rresp, axi_mst_rlast
  );

  modport slave (
    input  axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
           axi_mst_arsize, axi_mst_arburst, axi_mst_rready,
    output axi_mst_arready, axi_mst_rvalid, axi_mst_rid, axi_mst_rdata,
           axi_mst_rresp, axi_mst_rlast
  );
endinterface

// File: rtl/easyaxi_rd_mst.sv
// AXI read traffic generator: a ring of outstanding slots issues AR requests in order,
// accepts out-of-order R beats by ID, stores the data and retires slots in order.
module easyaxi_rd_mst #(
  parameter int          OST_DEPTH     = 16,
  parameter int          MAX_BURST_LEN = 8,
  parameter int          RREADY_MODE   = 0,
  parameter logic [31:0] ADDR_BASE     = 32'h0,
  parameter int          ID_W          = 4,
  parameter int          ADDR_W        = 32,
  parameter int          DATA_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 error,
  output logic                 proto_err,
  output logic [31:0]          done_cnt,
  easyaxi_rd_mst_if.master     axi
);

  localparam int IDX_W = $clog2(OST_DEPTH);
  localparam int CNT_W = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1;

  // Slot payload is a pure function of the slot index, so it is recomputed from the pointer.
  function automatic logic [7:0] slot_len(input int k);
    return 8'(k % MAX_BURST_LEN);
  endfunction

  function automatic logic [1:0] slot_burst(input int k);
    logic [7:0] len;
    len = slot_len(k);
    case (k % 3)
      0:       return 2'b01;
      1:       return 2'b00;
      default: return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ? 2'b10 : 2'b01;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(input int k);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(ADDR_BASE) + ADDR_W'(k * MAX_BURST_LEN * 4);
    if (slot_burst(k) == 2'b10) a = a + ADDR_W'(4);
    return a;
  endfunction

  logic [IDX_W-1:0] set_ptr_q, set_ptr_d;
  logic [IDX_W-1:0] req_ptr_q, req_ptr_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic             rready_q, rready_d;
  logic             error_q, error_d;
  logic             proto_err_q, proto_err_d;
  logic [31:0]      done_cnt_q, done_cnt_d;

  logic [OST_DEPTH-1:0] valid_vec, req_vec, comp_vec, err_vec;
  logic [CNT_W-1:0]     cnt_arr [OST_DEPTH];

  logic             full, alloc, ar_hs, beat, hit, retire, bad_len, id_ok;
  logic [IDX_W-1:0] rid_idx;
  logic [CNT_W-1:0] hit_cnt;

  assign full    = &valid_vec;
  assign alloc   = enable & ~full;
  assign ar_hs   = axi.axi_mst_arvalid & axi.axi_mst_arready;
  assign beat    = axi.axi_mst_rvalid & rready_q;
  assign rid_idx = axi.axi_mst_rid[IDX_W-1:0];
  assign id_ok   = (axi.axi_mst_rid >> IDX_W) == '0;
  assign hit     = beat & id_ok & valid_vec[rid_idx] & comp_vec[rid_idx] & ~req_vec[rid_idx];
  assign hit_cnt = cnt_arr[rid_idx];
  assign retire  = valid_vec[clr_ptr_q] & ~req_vec[clr_ptr_q] & ~comp_vec[clr_ptr_q];

  always_comb begin
    bad_len = 1'b0;
    if (hit) begin
      if (axi.axi_mst_rlast) bad_len = 8'(hit_cnt) != slot_len(int'(rid_idx));
      else                   bad_len = 8'(hit_cnt) == slot_len(int'(rid_idx));
    end
  end

  always_comb begin
    set_ptr_d   = set_ptr_q + IDX_W'(alloc);
    req_ptr_d   = req_ptr_q + IDX_W'(ar_hs);
    clr_ptr_d   = clr_ptr_q + IDX_W'(retire);
    rready_d    = (RREADY_MODE != 0) ? ~rready_q : 1'b1;
    error_d     = error_q | (|err_vec);
    proto_err_d = proto_err_q | (beat & ~hit) | bad_len;
    done_cnt_d  = done_cnt_q + 32'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_ptr_q   <= '0;
      req_ptr_q   <= '0;
      clr_ptr_q   <= '0;
      rready_q    <= 1'b1;
      error_q     <= 1'b0;
      proto_err_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      set_ptr_q   <= set_ptr_d;
      req_ptr_q   <= req_ptr_d;
      clr_ptr_q   <= clr_ptr_d;
      rready_q    <= rready_d;
      error_q     <= error_d;
      proto_err_q <= proto_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Each slot sees its own alloc / AR / beat / retire strobes; they may coincide across slots.
  for (genvar gi = 0; gi < OST_DEPTH; gi++) begin : g_slot
    logic              valid_q, valid_d, req_q, req_d, comp_q, comp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] data_q [MAX_BURST_LEN];
    logic [DATA_W-1:0] data_d [MAX_BURST_LEN];
    logic              set_hit, ar_hit, beat_hit, ret_hit;

    assign set_hit  = alloc  && (set_ptr_q == IDX_W'(gi));
    assign ar_hit   = ar_hs  && (req_ptr_q == IDX_W'(gi));
    assign beat_hit = hit    && (rid_idx   == IDX_W'(gi));
    assign ret_hit  = retire && (clr_ptr_q == IDX_W'(gi));

    always_comb begin
      valid_d = valid_q;
      req_d   = req_q;
      comp_d  = comp_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      data_d  = data_q;
      if (set_hit) begin
        valid_d = 1'b1;
        req_d   = 1'b1;
        comp_d  = 1'b1;
        cnt_d   = '0;
        resp_d  = 2'b00;
      end
      if (ar_hit) req_d = 1'b0;
      if (beat_hit) begin
        cnt_d         = cnt_q + 1'b1;
        data_d[cnt_q] = axi.axi_mst_rdata;
        if (axi.axi_mst_rresp > resp_q) resp_d = axi.axi_mst_rresp;
        if (axi.axi_mst_rlast) comp_d = 1'b0;
      end
      if (ret_hit) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        req_q   <= 1'b0;
        comp_q  <= 1'b0;
        cnt_q   <= '0;
        resp_q  <= 2'b00;
        for (int b = 0; b < MAX_BURST_LEN; b++) data_q[b] <= '0;
      end else begin
        valid_q <= valid_d;
        req_q   <= req_d;
        comp_q  <= comp_d;
        cnt_q   <= cnt_d;
        resp_q  <= resp_d;
        data_q  <= data_d;
      end
    end

    assign valid_vec[gi] = valid_q;
    assign req_vec[gi]   = req_q;
    assign comp_vec[gi]  = comp_q;
    assign err_vec[gi]   = resp_q[1];
    assign cnt_arr[gi]   = cnt_q;
  end

  assign axi.axi_mst_arvalid = req_vec[req_ptr_q];
  assign axi.axi_mst_arid    = ID_W'(req_ptr_q);
  assign axi.axi_mst_arlen   = slot_len(int'(req_ptr_q));
  assign axi.axi_mst_arsize  = 3'b010;
  assign axi.axi_mst_arburst = slot_burst(int'(req_ptr_q));
  assign axi.axi_mst_araddr  = slot_addr(int'(req_ptr_q));
  assign axi.axi_mst_rready  = rready_q;

  assign error     = error_q;
  assign proto_err = proto_err_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_easyaxi_rd_mst.sv
// Directed bench for easyaxi_rd_mst: dut0 uses constant rready, dut1 toggles rready.
// The bench plays the AXI slave and checks AR payloads, stored data, flags and counters.
module tb_easyaxi_rd_mst;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, enable0, enable1;
  logic error0, error1, proto0, proto1;
  logic [31:0] done0, done1;
  int checks = 0;
  int errors = 0;

  easyaxi_rd_mst_if if0 ();
  easyaxi_rd_mst_if if1 ();

  easyaxi_rd_mst #(.RREADY_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .enable(enable0), .error(error0),
    .proto_err(proto0), .done_cnt(done0), .axi(if0)
  );

  easyaxi_rd_mst #(.RREADY_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .enable(enable1), .error(error1),
    .proto_err(proto1), .done_cnt(done1), .axi(if1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bdata(input int id, input int b);
    return 32'hA500_0000 | 32'(id << 8) | 32'(b);
  endfunction

  task automatic drive_r(input int sel, input logic v, input logic [3:0] id,
                         input logic [31:0] d, input logic [1:0] resp, input logic last);
    if (sel == 0) begin
      if0.axi_mst_rvalid = v; if0.axi_mst_rid = id; if0.axi_mst_rdata = d;
      if0.axi_mst_rresp = resp; if0.axi_mst_rlast = last;
    end else begin
      if1.axi_mst_rvalid = v; if1.axi_mst_rid = id; if1.axi_mst_rdata = d;
      if1.axi_mst_rresp = resp; if1.axi_mst_rlast = last;
    end
  endtask

  // Called at a negedge; holds the beat until an edge where rready was high, returns at a negedge.
  task automatic send_beat(input int sel, input int id, input int b,
                           input logic [1:0] resp, input logic last);
    logic rr;
    int n;
    drive_r(sel, 1'b1, 4'(id), bdata(id, b), resp, last);
    n = 0;
    do begin
      rr = (sel == 0) ? if0.axi_mst_rready : if1.axi_mst_rready;
      @(posedge clk);
      n++;
    end while (!rr && n < 4);
    if (!rr) check("rbeat_timeout", 64'(rr), 64'd1);
    @(negedge clk);
    drive_r(sel, 1'b0, 4'd0, 32'd0, 2'd0, 1'b0);
    $display("R beat dut%0d id=%0d beat=%0d resp=%0d last=%0b", sel, id, b, resp, last);
  endtask

  task automatic send_burst(input int sel, input int id, input int len);
    for (int b = 0; b <= len; b++) send_beat(sel, id, b, 2'd0, b == len);
  endtask

  // Expected AR payload for slots 0..15 with MAX_BURST_LEN=8, ADDR_BASE=0.
  logic [1:0]  exp_burst [16] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0,
                                  2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1};
  logic [31:0] exp_addr  [16] = '{32'd0,   32'd32,  32'd64,  32'd96,  32'd128, 32'd160,
                                  32'd192, 32'd224, 32'd256, 32'd288, 32'd320, 32'd356,
                                  32'd384, 32'd416, 32'd448, 32'd480};

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; enable0 = 1'b0; enable1 = 1'b0;
    if0.axi_mst_arready = 1'b0; if1.axi_mst_arready = 1'b0;
    drive_r(0, 1'b0, 4'd0, 32'd0, 2'd0, 1'b0);
    drive_r(1, 1'b0, 4'd0, 32'd0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);

    check("rst_arvalid", 64'(if0.axi_mst_arvalid), 64'd0);
    check("rst_rready", 64'(if0.axi_mst_rready), 64'd1);
    check("rst_error", 64'(error0), 64'd0);
    check("rst_proto", 64'(proto0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);

    // Allocation latency and back-pressure on AR
    rst0_n = 1'b1;
    @(negedge clk);
    check("idle_arvalid", 64'(if0.axi_mst_arvalid), 64'd0);
    enable0 = 1'b1;
    @(negedge clk);
    check("alloc_lat_arvalid", 64'(if0.axi_mst_arvalid), 64'd1);
    check("alloc_lat_arid", 64'(if0.axi_mst_arid), 64'd0);
    repeat (20) @(negedge clk);
    check("hold_arvalid", 64'(if0.axi_mst_arvalid), 64'd1);
    check("hold_arid", 64'(if0.axi_mst_arid), 64'd0);
    check("hold_araddr", 64'(if0.axi_mst_araddr), 64'd0);
    check("hold_arlen", 64'(if0.axi_mst_arlen), 64'd0);
    check("full", 64'(u_dut0.full), 64'd1);
    check("valid_all", 64'(u_dut0.valid_vec), 64'hFFFF);
    enable0 = 1'b0;

    // Drain the 16 requests, one per cycle
    if0.axi_mst_arready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ar_valid_%0d", k), 64'(if0.axi_mst_arvalid), 64'd1);
      check($sformatf("ar_id_%0d", k), 64'(if0.axi_mst_arid), 64'(k));
      check($sformatf("ar_len_%0d", k), 64'(if0.axi_mst_arlen), 64'(k % 8));
      check($sformatf("ar_size_%0d", k), 64'(if0.axi_mst_arsize), 64'd2);
      check($sformatf("ar_burst_%0d", k), 64'(if0.axi_mst_arburst), 64'(exp_burst[k]));
      check($sformatf("ar_addr_%0d", k), 64'(if0.axi_mst_araddr), 64'(exp_addr[k]));
      $display("AR dut0 id=%0d len=%0d addr=%0h", if0.axi_mst_arid, if0.axi_mst_arlen,
               if0.axi_mst_araddr);
      @(negedge clk);
    end
    if0.axi_mst_arready = 1'b0;
    check("ar_drained", 64'(if0.axi_mst_arvalid), 64'd0);

    // Out-of-order completion: slot 0, then 2, then 1
    send_burst(0, 0, 0);
    @(negedge clk);
    check("done_after0", 64'(done0), 64'd1);
    send_burst(0, 2, 2);
    repeat (2) @(negedge clk);
    check("done_blocked", 64'(done0), 64'd1);
    for (int b = 0; b < 3; b++)
      check($sformatf("slot2_data_%0d", b), 64'(u_dut0.g_slot[2].data_q[b]), 64'(bdata(2, b)));
    send_burst(0, 1, 1);
    check("done_pre1", 64'(done0), 64'd1);
    @(negedge clk);
    check("done_ret1", 64'(done0), 64'd2);
    @(negedge clk);
    check("done_ret2", 64'(done0), 64'd3);
    check("slot1_data_1", 64'(u_dut0.g_slot[1].data_q[1]), 64'(bdata(1, 1)));
    for (int k = 3; k < 16; k++) send_burst(0, k, k % 8);
    repeat (4) @(negedge clk);
    check("done_16", 64'(done0), 64'd16);
    check("clean_error", 64'(error0), 64'd0);
    check("clean_proto", 64'(proto0), 64'd0);

    // Second round: slots 0..3, then SLVERR on id 1 and short burst on id 3
    enable0 = 1'b1; if0.axi_mst_arready = 1'b1;
    repeat (4) @(negedge clk);
    enable0 = 1'b0;
    repeat (4) @(negedge clk);
    if0.axi_mst_arready = 1'b0;
    check("round2_valid", 64'(u_dut0.valid_vec), 64'h000F);
    send_beat(0, 1, 0, 2'd2, 1'b0);
    send_beat(0, 1, 1, 2'd0, 1'b1);
    repeat (2) @(negedge clk);
    check("slverr_error", 64'(error0), 64'd1);
    check("slverr_noproto", 64'(proto0), 64'd0);
    send_beat(0, 3, 0, 2'd0, 1'b0);
    send_beat(0, 3, 1, 2'd0, 1'b0);
    check("early_noproto", 64'(proto0), 64'd0);
    send_beat(0, 3, 2, 2'd0, 1'b1);
    check("early_rlast_proto", 64'(proto0), 64'd1);
    repeat (5) @(negedge clk);
    check("error_sticky", 64'(error0), 64'd1);
    check("proto_sticky", 64'(proto0), 64'd1);

    // Reset in the middle of the id 2 burst
    send_beat(0, 2, 0, 2'd0, 1'b0);
    rst0_n = 1'b0;
    #1;
    check("mrst_arvalid", 64'(if0.axi_mst_arvalid), 64'd0);
    check("mrst_rready", 64'(if0.axi_mst_rready), 64'd1);
    check("mrst_error", 64'(error0), 64'd0);
    check("mrst_proto", 64'(proto0), 64'd0);
    check("mrst_done", 64'(done0), 64'd0);
    check("mrst_valid", 64'(u_dut0.valid_vec), 64'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    send_beat(0, 2, 1, 2'd0, 1'b0);
    check("unmatched_proto", 64'(proto0), 64'd1);
    enable0 = 1'b1;
    @(negedge clk);
    enable0 = 1'b0;
    check("restart_arvalid", 64'(if0.axi_mst_arvalid), 64'd1);
    check("restart_arid", 64'(if0.axi_mst_arid), 64'd0);

    // Toggling rready: 8-beat burst on id 7
    check("m1_rst_rready", 64'(if1.axi_mst_rready), 64'd1);
    rst1_n = 1'b1;
    check("m1_rr_0", 64'(if1.axi_mst_rready), 64'd1);
    @(negedge clk);
    check("m1_rr_1", 64'(if1.axi_mst_rready), 64'd0);
    @(negedge clk);
    check("m1_rr_2", 64'(if1.axi_mst_rready), 64'd1);
    enable1 = 1'b1; if1.axi_mst_arready = 1'b1;
    repeat (8) @(negedge clk);
    enable1 = 1'b0;
    repeat (4) @(negedge clk);
    if1.axi_mst_arready = 1'b0;
    check("m1_valid", 64'(u_dut1.valid_vec), 64'h00FF);
    // Start on a cycle with rready low so the first beat is held over it
    if (if1.axi_mst_rready) @(negedge clk);
    send_burst(1, 7, 7);
    for (int b = 0; b < 8; b++)
      check($sformatf("m1_slot7_data_%0d", b), 64'(u_dut1.g_slot[7].data_q[b]), 64'(bdata(7, b)));
    check("m1_proto", 64'(proto1), 64'd0);
    check("m1_error", 64'(error1), 64'd0);
    check("m1_comp7", 64'(u_dut1.comp_vec[7]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
